// File: rtl/mem_pkg.sv
// Shared types and width helpers for the cache miss/refill controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    RD,
    INSTALL
  } state_e;

  function automatic int ofs_w(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int line_w(input int ww, input int wpl);
    return ww * wpl;
  endfunction

  function automatic int maddr_w(input int aw, input int wpl);
    return aw - $clog2(wpl);
  endfunction

  function automatic int idx_w(input int aw, input int wpl,
                               input int tw);
    return aw - $clog2(wpl) - tw;
  endfunction

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PW        = ptr_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PW-1:0]        idx,
  output logic                 any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = (int'(ptr) + i) % NUM_PORTS;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss/refill controller: arbitration, victim writeback, fill, store merge.
// MISS_PERF_CNT_EN adds per-port service and writeback counters.
module cache_miss_ctrl
  import mem_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 16,
  parameter int WORD_W         = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PORTS-1:0]  req_valid,
  input  logic [NUM_PORTS-1:0]  req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*WORD_W-1:0] req_wdata,
  input  logic [NUM_PORTS-1:0]  vict_dirty,
  input  logic [NUM_PORTS*TAG_W-1:0]  vict_tag,
  input  logic [NUM_PORTS*line_w(WORD_W,WORDS_PER_LINE)-1:0]
                                vict_line,
  output logic [NUM_PORTS-1:0]  fill_we,
  output logic [line_w(WORD_W,WORDS_PER_LINE)-1:0] fill_line,
  output logic                  fill_dirty,
  output logic [NUM_PORTS-1:0]  done,
  output logic [maddr_w(ADDR_W,WORDS_PER_LINE)-1:0] m_addr,
  output logic                  m_re,
  output logic                  m_we,
  output logic [line_w(WORD_W,WORDS_PER_LINE)-1:0] m_wdata,
  input  logic [line_w(WORD_W,WORDS_PER_LINE)-1:0] m_rdata,
  input  logic                  m_rdy
`ifdef MISS_PERF_CNT_EN
  ,
  output logic [NUM_PORTS*16-1:0] perf_miss,
  output logic [15:0]             perf_wb
`endif
);

  localparam int OFS_W   = ofs_w(WORDS_PER_LINE);
  localparam int LINE_W  = line_w(WORD_W, WORDS_PER_LINE);
  localparam int MADDR_W = maddr_w(ADDR_W, WORDS_PER_LINE);
  localparam int IDX_W   = idx_w(ADDR_W, WORDS_PER_LINE, TAG_W);
  localparam int PW      = ptr_w(NUM_PORTS);

  // line holds the victim during WB, then the read line after RD
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } txn_t;

  state_e               state_q, state_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [NUM_PORTS-1:0] goh_q, goh_d;
  txn_t                 txn_q, txn_d;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PW-1:0]        arb_idx;
  logic                 arb_any;
  logic [IDX_W-1:0]     idx;
  int                   gi;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .PW       (PW)
  ) u_arb (
    .req(req_valid),
    .ptr(rr_q),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );

  assign gi  = int'(arb_idx);
  assign idx = txn_q.addr[ADDR_W-TAG_W-1:OFS_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gidx_q  <= '0;
      goh_q   <= '0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      goh_q   <= goh_d;
      txn_q   <= txn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gidx_d     = gidx_q;
    goh_d      = goh_q;
    txn_d      = txn_q;
    fill_we    = '0;
    fill_line  = '0;
    fill_dirty = 1'b0;
    done       = '0;
    m_addr     = '0;
    m_re       = 1'b0;
    m_we       = 1'b0;
    m_wdata    = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          gidx_d      = arb_idx;
          goh_d       = arb_gnt;
          txn_d.we    = req_we[arb_idx];
          txn_d.addr  = req_addr[gi*ADDR_W +: ADDR_W];
          txn_d.wdata = req_wdata[gi*WORD_W +: WORD_W];
          txn_d.tag   = vict_tag[gi*TAG_W +: TAG_W];
          txn_d.line  = vict_line[gi*LINE_W +: LINE_W];
          state_d     = vict_dirty[arb_idx] ? WB : RD;
        end
      end
      WB: begin
        m_we    = 1'b1;
        m_addr  = {txn_q.tag, idx};
        m_wdata = txn_q.line;
        if (m_rdy) state_d = RD;
      end
      RD: begin
        m_re   = 1'b1;
        m_addr = txn_q.addr[ADDR_W-1:OFS_W];
        if (m_rdy) begin
          txn_d.line = m_rdata;
          state_d    = INSTALL;
        end
      end
      INSTALL: begin
        fill_we    = goh_q;
        done       = goh_q;
        fill_dirty = txn_q.we;
        fill_line  = txn_q.line;
        if (txn_q.we)
          fill_line[int'(txn_q.addr[OFS_W-1:0])*WORD_W +: WORD_W]
            = txn_q.wdata;
        rr_d = (int'(gidx_q) == NUM_PORTS-1) ? '0
             : gidx_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MISS_PERF_CNT_EN
  logic [NUM_PORTS-1:0][15:0] pm_q, pm_d;
  logic [15:0]                pw_q, pw_d;
  logic                       wb_q, wb_d;

  always_comb begin
    pm_d = pm_q;
    pw_d = pw_q;
    wb_d = wb_q;
    if (state_q == IDLE && arb_any) wb_d = vict_dirty[arb_idx];
    if (state_q == INSTALL) begin
      if (pm_q[gidx_q] != 16'hFFFF)
        pm_d[gidx_q] = pm_q[gidx_q] + 16'd1;
      if (wb_q && pw_q != 16'hFFFF) pw_d = pw_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pm_q <= '0;
      pw_q <= '0;
      wb_q <= 1'b0;
    end else begin
      pm_q <= pm_d;
      pw_q <= pw_d;
      wb_q <= wb_d;
    end
  end

  assign perf_miss = pm_q;
  assign perf_wb   = pw_q;
`endif

endmodule
